// File: rtl/anita3_event_readout.sv
// anita3_event_readout: drains one completed event buffer word by word onto a
// valid/ready stream, then releases the buffer with a single clr_evt_o pulse
// and waits a programmable holdoff before looking for the next event.
module anita3_event_readout #(
  parameter int unsigned EVENT_WORDS = 16,  // 32-bit words per event, 2..64
  parameter int unsigned HOLDOFF     = 4    // cycles between clear and re-arm, 1..15
) (
  input  logic        clk33_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic        evt_ready_i,
  output logic [5:0]  event_addr_o,
  input  logic [31:0] event_dat_i,
  output logic        clr_evt_o,
  output logic [31:0] m_tdata_o,
  output logic        m_tvalid_o,
  input  logic        m_tready_i,
  output logic        m_tlast_o,
  output logic        busy_o,
  output logic [15:0] evt_count_o
);

  typedef enum logic [2:0] {
    IDLE,   // waiting for enable_i && evt_ready_i
    ADDR,   // address presented, buffer read in flight
    LOAD,   // read data valid, capture into the stream register
    SEND,   // word offered downstream until accepted
    CLEAR,  // release the buffer
    HOLD    // give the buffer writer time to drop evt_ready_i
  } state_t;

  localparam logic [5:0] LAST_ADDR = 6'(EVENT_WORDS - 1);
  localparam logic [3:0] HOLD_LAST = 4'(HOLDOFF - 1);

  logic       rst_sync_n;
  state_t     state_q;
  state_t     state_d;
  logic [3:0] hold_cnt_q;
  logic       last_word;

  assign last_word = (event_addr_o == LAST_ADDR);
  assign busy_o    = (state_q != IDLE);

  // Reset asserts immediately but releases through one flop, so every
  // register below leaves reset on the same clean edge.
  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync_n <= 1'b0;
    else          rst_sync_n <= 1'b1;
  end

  // State register.
  // NOTE: clocked state always uses <= so every flop samples pre-edge values;
  // a blocking = here would let later statements see the updated value.
  always_ff @(posedge clk33_i or negedge rst_sync_n) begin
    if (!rst_sync_n) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Next-state decode. The event is committed once ADDR is entered: enable_i
  // and evt_ready_i are not looked at again until the FSM is back in IDLE.
  always_comb begin
    // NOTE: default assigned before the case so no path leaves state_d
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_i && evt_ready_i) state_d = ADDR;
      ADDR:    state_d = LOAD;
      LOAD:    state_d = SEND;
      SEND:    if (m_tready_i) state_d = last_word ? CLEAR : ADDR;
      CLEAR:   state_d = HOLD;
      HOLD:    if (hold_cnt_q == HOLD_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stream register and word address: capture in LOAD, hold through SEND,
  // retire on handshake. The address wraps to 0 after the last word so it
  // already reads 0 in CLEAR, HOLD and IDLE.
  always_ff @(posedge clk33_i or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      event_addr_o <= 6'd0;
      m_tdata_o    <= 32'd0;
      m_tvalid_o   <= 1'b0;
      m_tlast_o    <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          m_tdata_o  <= event_dat_i;
          m_tvalid_o <= 1'b1;
          m_tlast_o  <= last_word;
        end
        SEND: begin
          if (m_tready_i) begin
            m_tvalid_o   <= 1'b0;
            m_tlast_o    <= 1'b0;
            event_addr_o <= last_word ? 6'd0 : event_addr_o + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer release pulse (high exactly while in CLEAR), event counter and
  // holdoff counter.
  always_ff @(posedge clk33_i or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      clr_evt_o   <= 1'b0;
      evt_count_o <= 16'd0;
      hold_cnt_q  <= 4'd0;
    end else begin
      clr_evt_o  <= (state_d == CLEAR);
      hold_cnt_q <= (state_q == HOLD) ? hold_cnt_q + 4'd1 : 4'd0;
      if (state_q == CLEAR) evt_count_o <= evt_count_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_anita3_event_readout.sv
// tb_anita3_event_readout: randomized self-checking bench. A negedge monitor
// records stream beats, clear pulses and busy edges; each test compares them
// against the expected event contents and cycle timing.
module tb_anita3_event_readout;

  localparam int EW = 16;

  logic        clk33 = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        evt_ready = 1'b0;
  logic [5:0]  event_addr;
  logic [31:0] event_dat = 32'd0;
  logic        clr_evt;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic        busy;
  logic [15:0] evt_count;

  int vectors = 0;
  int miscompares = 0;
  int ready_mode = 1;          // 0 = low, 1 = high, 2 = random 30 %
  logic [15:0] exp_count = 16'd0;

  logic [31:0] mem [64];

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          cyc;
  } beat_t;

  beat_t beats_q[$];
  int    clr_cyc_q[$];
  int    rise_q[$];
  int    fall_q[$];
  int    clr_cnt = 0;
  int    stab_err = 0, consec_err = 0, addr_err = 0, idle_err = 0, clr_err = 0;

  always #5 clk33 = ~clk33;

  anita3_event_readout #(.EVENT_WORDS(EW), .HOLDOFF(4)) dut (
    .clk33_i      (clk33),
    .rst_n_i      (rst_n),
    .enable_i     (enable),
    .evt_ready_i  (evt_ready),
    .event_addr_o (event_addr),
    .event_dat_i  (event_dat),
    .clr_evt_o    (clr_evt),
    .m_tdata_o    (m_tdata),
    .m_tvalid_o   (m_tvalid),
    .m_tready_i   (m_tready),
    .m_tlast_o    (m_tlast),
    .busy_o       (busy),
    .evt_count_o  (evt_count)
  );

  // Event buffer read port: one cycle of latency.
  always @(posedge clk33) event_dat <= mem[event_addr];

  // Downstream ready driver.
  initial forever begin
    @(posedge clk33);
    #1;
    case (ready_mode)
      0:       m_tready = 1'b0;
      1:       m_tready = 1'b1;
      default: m_tready = ($urandom_range(0, 99) < 30);
    endcase
  end

  // Monitor: samples on the falling edge and logs protocol observations.
  initial begin : monitor
    int cyc = 0;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0, pb = 1'b0, last_hs = 1'b0;
    logic [31:0] pd = 32'd0;
    forever begin
      @(negedge clk33);
      cyc++;
      if (!rst_n) begin
        pv = 1'b0; pr = 1'b0; pb = 1'b0; last_hs = 1'b0;
      end else begin
        if (pv && !pr && (!m_tvalid || m_tdata !== pd || m_tlast !== pl)) stab_err++;
        if (pv && pr && m_tvalid) consec_err++;
        if (event_addr > 6'(EW - 1)) addr_err++;
        if (!busy && (event_addr !== 6'd0 || m_tvalid)) idle_err++;
        if (clr_evt) begin
          clr_cnt++;
          clr_cyc_q.push_back(cyc);
          if (!last_hs) clr_err++;
          last_hs = 1'b0;
        end
        if (m_tvalid && m_tready) begin
          beats_q.push_back(beat_t'{m_tdata, m_tlast, cyc});
          if (m_tlast) last_hs = 1'b1;
        end
        if (busy && !pb) rise_q.push_back(cyc);
        if (!busy && pb) fall_q.push_back(cyc);
        pv = m_tvalid; pr = m_tready; pd = m_tdata; pl = m_tlast; pb = busy;
      end
    end
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk33);
    #1;
  endtask

  task automatic settle();
    enable = 1'b0;
    evt_ready = 1'b0;
    repeat (12) tick();
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int k = 0;
    while (beats_q.size() < n && k < budget) begin tick(); k++; end
    vectors++;
    if (beats_q.size() < n) begin
      miscompares++;
      $display("FAIL %s_beat_timeout: got %0d beats want %0d", tag, beats_q.size(), n);
    end
  endtask

  task automatic wait_clr(input int n, input int budget, input string tag);
    int k = 0;
    while (clr_cnt < n && k < budget) begin tick(); k++; end
    vectors++;
    if (clr_cnt < n) begin
      miscompares++;
      $display("FAIL %s_clr_timeout: got %0d clears want %0d", tag, clr_cnt, n);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    vectors += 7;
    if (m_tdata !== 32'd0)   begin miscompares++; $display("FAIL %s_tdata: got %h want 0", tag, m_tdata); end
    if (m_tvalid !== 1'b0)   begin miscompares++; $display("FAIL %s_tvalid: got %b want 0", tag, m_tvalid); end
    if (m_tlast !== 1'b0)    begin miscompares++; $display("FAIL %s_tlast: got %b want 0", tag, m_tlast); end
    if (clr_evt !== 1'b0)    begin miscompares++; $display("FAIL %s_clr: got %b want 0", tag, clr_evt); end
    if (busy !== 1'b0)       begin miscompares++; $display("FAIL %s_busy: got %b want 0", tag, busy); end
    if (event_addr !== 6'd0) begin miscompares++; $display("FAIL %s_addr: got %0d want 0", tag, event_addr); end
    if (evt_count !== 16'd0) begin miscompares++; $display("FAIL %s_count: got %h want 0", tag, evt_count); end
  endtask

  // Expected event: every buffer word once, in address order, tlast on the final one.
  task automatic check_event(input int base, input string tag);
    vectors++;
    if (beats_q.size() - base != EW) begin
      miscompares++;
      $display("FAIL %s_beat_count: got %0d want %0d", tag, beats_q.size() - base, EW);
    end
    for (int i = 0; i < EW && base + i < beats_q.size(); i++) begin
      vectors += 2;
      if (beats_q[base+i].data !== mem[i]) begin
        miscompares++;
        $display("FAIL %s_data[%0d]: got %h want %h", tag, i, beats_q[base+i].data, mem[i]);
      end
      if (beats_q[base+i].last !== (i == EW - 1)) begin
        miscompares++;
        $display("FAIL %s_last[%0d]: got %b want %b", tag, i, beats_q[base+i].last, i == EW - 1);
      end
    end
  endtask

  task automatic check_count(input string tag);
    vectors++;
    if (evt_count !== exp_count) begin
      miscompares++;
      $display("FAIL %s_evt_count: got %h want %h", tag, evt_count, exp_count);
    end
  endtask

  task automatic test_reset();
    int cb;
    rst_n = 1'b0;
    ready_mode = 1;
    repeat (3) tick();
    check_zero_outputs("reset");
    enable = 1'b1;
    evt_ready = 1'b1;
    #2 rst_n = 1'b1;
    @(posedge clk33); #1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_release_edge1: got busy %b want 0", busy); end
    @(posedge clk33); #1;
    vectors += 2;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_release_edge2: got busy %b want 1", busy); end
    if (event_addr !== 6'd0) begin miscompares++; $display("FAIL reset_first_addr: got %0d want 0", event_addr); end
    evt_ready = 1'b0;
    cb = clr_cnt;
    wait_clr(cb + 1, 400, "reset");
    exp_count++;
    settle();
    check_count("reset");
  endtask

  task automatic test_basic();
    int base, cb;
    for (int n = 0; n < 64; n++) mem[n] = 32'hA5A50000 + n;
    ready_mode = 1;
    base = beats_q.size();
    cb = clr_cnt;
    enable = 1'b1;
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    wait_clr(cb + 1, 200, "basic");
    exp_count++;
    settle();
    check_event(base, "basic");
    for (int i = 1; i < EW && base + i < beats_q.size(); i++) begin
      vectors++;
      if (beats_q[base+i].cyc - beats_q[base+i-1].cyc != 3) begin
        miscompares++;
        $display("FAIL basic_spacing[%0d]: got %0d cycles want 3", i,
                 beats_q[base+i].cyc - beats_q[base+i-1].cyc);
      end
    end
    vectors += 2;
    if (clr_cnt - cb != 1) begin miscompares++; $display("FAIL basic_clr_pulses: got %0d want 1", clr_cnt - cb); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_idle_after: got busy %b want 0", busy); end
    check_count("basic");
  endtask

  task automatic test_random_ready();
    int base, cb;
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 64; n++) mem[n] = $urandom;
      ready_mode = 2;
      base = beats_q.size();
      cb = clr_cnt;
      enable = 1'b1;
      evt_ready = 1'b1;
      wait_beats(base + 1, 400, "random");
      evt_ready = 1'b0;   // buffer flag falls mid-event; readout must still finish
      wait_clr(cb + 1, 2000, "random");
      exp_count++;
      ready_mode = 1;
      settle();
      check_event(base, "random");
      check_count("random");
    end
  endtask

  task automatic test_enable_drop();
    int base, cb, rb;
    for (int n = 0; n < 64; n++) mem[n] = $urandom;
    ready_mode = 1;
    base = beats_q.size();
    cb = clr_cnt;
    rb = rise_q.size();
    enable = 1'b1;
    evt_ready = 1'b1;
    wait_beats(base + 6, 400, "endrop");
    enable = 1'b0;
    wait_clr(cb + 1, 400, "endrop");
    exp_count++;
    repeat (30) tick();
    check_event(base, "endrop");
    vectors += 3;
    if (clr_cnt - cb != 1) begin miscompares++; $display("FAIL endrop_clr_pulses: got %0d want 1", clr_cnt - cb); end
    if (rise_q.size() - rb != 1) begin miscompares++; $display("FAIL endrop_restart: got %0d starts want 1", rise_q.size() - rb); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL endrop_busy: got %b want 0", busy); end
    settle();
    check_count("endrop");
  endtask

  task automatic test_mid_reset();
    int base, cb;
    for (int n = 0; n < 64; n++) mem[n] = $urandom | 32'h1;
    ready_mode = 1;
    base = beats_q.size();
    cb = clr_cnt;
    enable = 1'b1;
    evt_ready = 1'b1;
    wait_beats(base + 9, 400, "midrst");
    tick();
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    exp_count = 16'd0;
    repeat (2) tick();
    vectors++;
    if (clr_cnt != cb) begin miscompares++; $display("FAIL midrst_no_clr: got %0d clears want %0d", clr_cnt, cb); end
    base = beats_q.size();
    rst_n = 1'b1;
    wait_beats(base + 1, 400, "midrst");
    evt_ready = 1'b0;
    wait_clr(cb + 1, 400, "midrst");
    exp_count++;
    settle();
    check_event(base, "midrst");
    check_count("midrst");
  endtask

  task automatic test_wrap();
    int cb;
    ready_mode = 1;
    force dut.evt_count_o = 16'hFFFF;
    tick();
    release dut.evt_count_o;
    exp_count = 16'hFFFF;
    tick();
    check_count("wrap_preload");
    cb = clr_cnt;
    enable = 1'b1;
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    wait_clr(cb + 1, 400, "wrap");
    exp_count++;
    settle();
    check_count("wrap");
  endtask

  task automatic test_holdoff();
    int cb, c0, fall, rise;
    ready_mode = 1;
    cb = clr_cnt;
    enable = 1'b1;
    evt_ready = 1'b1;
    wait_clr(cb + 2, 400, "holdoff");
    enable = 1'b0;
    evt_ready = 1'b0;
    exp_count += 16'd2;
    settle();
    c0 = (clr_cyc_q.size() > cb) ? clr_cyc_q[cb] : 0;
    fall = -1;
    rise = -1;
    foreach (fall_q[i]) if (fall < 0 && fall_q[i] > c0) fall = fall_q[i];
    foreach (rise_q[i]) if (rise < 0 && rise_q[i] > c0) rise = rise_q[i];
    vectors += 3;
    if (fall - c0 != 5) begin miscompares++; $display("FAIL holdoff_idle: got %0d cycles want 5", fall - c0); end
    if (rise - c0 != 6) begin miscompares++; $display("FAIL holdoff_addr: got %0d cycles want 6", rise - c0); end
    if (clr_cyc_q.size() < cb + 2 || clr_cyc_q[cb+1] - c0 != 6 + 3 * EW) begin
      miscompares++;
      $display("FAIL holdoff_period: got %0d cycles want %0d",
               (clr_cyc_q.size() < cb + 2) ? -1 : clr_cyc_q[cb+1] - c0, 6 + 3 * EW);
    end
    check_count("holdoff");
  endtask

  task automatic test_invariants();
    vectors += 5;
    if (stab_err != 0)   begin miscompares++; $display("FAIL inv_stall_stable: got %0d violations want 0", stab_err); end
    if (consec_err != 0) begin miscompares++; $display("FAIL inv_valid_gap: got %0d violations want 0", consec_err); end
    if (addr_err != 0)   begin miscompares++; $display("FAIL inv_addr_range: got %0d violations want 0", addr_err); end
    if (idle_err != 0)   begin miscompares++; $display("FAIL inv_idle_outputs: got %0d violations want 0", idle_err); end
    if (clr_err != 0)    begin miscompares++; $display("FAIL inv_clr_after_last: got %0d violations want 0", clr_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_ready();
    test_enable_drop();
    test_mid_reset();
    test_wrap();
    test_holdoff();
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
